// File: rtl/sysref_pkg.sv
// Shared types and defaults for the multi-channel SYSREF capture monitor.
package sysref_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } cap_state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PERIOD_W    = 16;
  localparam int DEF_TOL         = 0;
  localparam int DEF_LOCK_COUNT  = 4;

  // Width needed to hold a match counter that saturates at lock_count.
  function automatic int mcount_width(input int lock_count);
    return $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/sysref_chan_mon.sv
// Per-channel SYSREF monitor: synchroniser, rising-edge detect, period
// measurement and lock/error tracking against an expected period.
module sysref_chan_mon
  import sysref_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PERIOD_W    = DEF_PERIOD_W,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input  logic                pl_clk,
  input  logic                pl_rstn,
  input  logic                sysref_in,
  input  logic [PERIOD_W-1:0] expected_period,
  input  logic                clear_err,
  output logic                sysref_out,
  output logic                sysref_edge,
  output logic [PERIOD_W-1:0] period_meas,
  output logic                locked,
  output logic                err_sticky
);

  localparam int MC_W  = mcount_width(LOCK_COUNT);
  localparam int MCX_W = MC_W + 1;
  localparam int EXT_W = PERIOD_W + 1;
  localparam logic [PERIOD_W-1:0] CNT_MAX     = '1;
  localparam logic [EXT_W-1:0]    TOL_EXT     = EXT_W'(TOL);
  localparam logic [MCX_W-1:0]    LOCK_TARGET = MCX_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]     LOCK_MAX    = MC_W'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   prev_reg;
  logic                   sync_last, edge_det;
  logic [PERIOD_W-1:0]    cnt_reg, meas_reg;
  logic                   seen_reg, locked_reg, err_reg;
  logic [MC_W-1:0]        mcount_reg;
  logic [MCX_W-1:0]       mcount_inc;
  logic [EXT_W-1:0]       cnt_ext, exp_ext, diff, limit;
  logic                   match, measure, missing, err_event;

  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      assign sync_next = sysref_in;
    end else begin : g_syncn
      assign sync_next = {sync_reg[SYNC_STAGES-2:0], sysref_in};
    end
  endgenerate

  assign sync_last = sync_reg[SYNC_STAGES-1];
  assign edge_det  = sync_last & ~prev_reg;

  // Widened by one bit so the difference and limit never wrap.
  assign cnt_ext    = {1'b0, cnt_reg};
  assign exp_ext    = {1'b0, expected_period};
  assign diff       = (cnt_ext >= exp_ext) ? (cnt_ext - exp_ext) : (exp_ext - cnt_ext);
  assign limit      = exp_ext + TOL_EXT;
  assign match      = (expected_period != '0) && (diff <= TOL_EXT);
  assign measure    = edge_det & seen_reg;
  assign missing    = locked_reg & ~edge_det & (cnt_ext > limit);
  assign err_event  = (measure & ~match & locked_reg) | missing;
  assign mcount_inc = {1'b0, mcount_reg} + 1'b1;

  always_ff @(posedge pl_clk) begin
    if (!pl_rstn) begin
      sync_reg   <= '0;
      prev_reg   <= 1'b0;
      cnt_reg    <= '0;
      meas_reg   <= '0;
      seen_reg   <= 1'b0;
      mcount_reg <= '0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_last;

      if (edge_det) begin
        seen_reg <= 1'b1;
        cnt_reg  <= PERIOD_W'(1);
        if (seen_reg) meas_reg <= cnt_reg;
      end else if (seen_reg && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (measure) begin
        if (match) begin
          mcount_reg <= (mcount_inc >= LOCK_TARGET) ? LOCK_MAX : mcount_inc[MC_W-1:0];
          if (mcount_inc >= LOCK_TARGET) locked_reg <= 1'b1;
        end else begin
          mcount_reg <= '0;
          locked_reg <= 1'b0;
        end
      end else if (missing) begin
        mcount_reg <= '0;
        locked_reg <= 1'b0;
      end

      // A fresh error outranks a clear in the same cycle.
      if (err_event) err_reg <= 1'b1;
      else if (clear_err) err_reg <= 1'b0;
    end
  end

  assign sysref_out  = sync_last;
  assign sysref_edge = edge_det;
  assign period_meas = meas_reg;
  assign locked      = locked_reg;
  assign err_sticky  = err_reg;

endmodule

// File: rtl/sysref_capture_monitor.sv
// Multi-channel PL SYSREF capture/monitor: per-channel monitors plus a shared
// arm/capture handshake recording which channels fire on the next edge.
module sysref_capture_monitor
  import sysref_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PERIOD_W    = DEF_PERIOD_W,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input  logic                       pl_clk,
  input  logic                       pl_rstn,
  input  logic [NUM_CH-1:0]          sysref_in,
  input  logic [PERIOD_W-1:0]        expected_period,
  input  logic                       arm,
  input  logic                       clear_err,
  output logic [NUM_CH-1:0]          sysref_out,
  output logic [NUM_CH-1:0]          sysref_edge,
  output logic [NUM_CH*PERIOD_W-1:0] period_meas,
  output logic [NUM_CH-1:0]          locked,
  output logic [NUM_CH-1:0]          err_sticky,
  output logic                       armed,
  output logic                       capture_done,
  output logic [NUM_CH-1:0]          capture_mask
);

  cap_state_t        state_reg, state_next;
  logic              capture_fire;
  logic              done_reg;
  logic [NUM_CH-1:0] mask_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      sysref_chan_mon #(
        .SYNC_STAGES (SYNC_STAGES),
        .PERIOD_W    (PERIOD_W),
        .TOL         (TOL),
        .LOCK_COUNT  (LOCK_COUNT)
      ) u_chan (
        .pl_clk          (pl_clk),
        .pl_rstn         (pl_rstn),
        .sysref_in       (sysref_in[gi]),
        .expected_period (expected_period),
        .clear_err       (clear_err),
        .sysref_out      (sysref_out[gi]),
        .sysref_edge     (sysref_edge[gi]),
        .period_meas     (period_meas[gi*PERIOD_W +: PERIOD_W]),
        .locked          (locked[gi]),
        .err_sticky      (err_sticky[gi])
      );
    end
  endgenerate

  always_ff @(posedge pl_clk) begin
    if (!pl_rstn) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= capture_fire;
      if (capture_fire) mask_reg <= sysref_edge;
    end
  end

  // Edges are only looked at once ARMED, so an edge coincident with arm is missed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (|sysref_edge) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    armed        = (state_reg == ARMED);
    capture_fire = (state_reg == ARMED) && (|sysref_edge);
  end

  assign capture_done = done_reg;
  assign capture_mask = mask_reg;

endmodule
